// File: rtl/imem_responder_if.sv
// Fetch/response/program-load bundle between a core and the instruction store.
// The master side is the core. The slave side is the responder.
interface imem_responder_if #(
    parameter int AW = 10
);
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic          rsp_err;
    logic          flush;
    logic          prog_en;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, prog_en, prog_addr, prog_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, prog_en, prog_addr, prog_data,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder.
// A DEPTH x 32 store is read synchronously into a 2-entry in-order response FIFO.
// An accepted fetch writes its word straight into the FIFO tail register.
// The response is therefore visible one cycle after acceptance, and the FIFO
// sustains one response per cycle.
module imem_responder #(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    imem_responder_if.slave   bus
);
    localparam int DEPTH = 2 ** AW;

    // Instruction store. Reset does not clear it.
    logic [31:0] mem [DEPTH];

    // Response FIFO storage: two entries of {instr, err}.
    logic [31:0] fifo_instr_q [2];
    logic        fifo_err_q   [2];

    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;

    logic        rsp_valid_int;
    logic        req_ready_int;
    logic        push;
    logic        pop;
    logic        in_range;
    logic [AW-1:0] rd_idx;

    assign rd_idx   = bus.req_addr[AW-1:0];
    assign in_range = (bus.req_addr[31:AW] == '0);

    // Handshake decode and next-state computation for the FIFO pointers and count.
    always_comb begin
        rsp_valid_int = (count_q != 2'd0);
        // A full FIFO can still accept a request when it pops in the same cycle.
        req_ready_int = !reset && !bus.flush && !bus.prog_en &&
                        ((count_q != 2'd2) || (rsp_valid_int && bus.rsp_ready));
        push          = bus.req_valid && req_ready_int;
        // A flush discards the head, so it overrides a pop.
        pop           = rsp_valid_int && bus.rsp_ready && !bus.flush;

        head_d  = head_q ^ pop;
        tail_d  = tail_q ^ push;
        count_d = count_q + 2'(push) - 2'(pop);

        if (bus.flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end
    end

    // State register for the pointers and the count.
    // Reset has priority over every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Registered memory read, landing directly in the FIFO tail entry.
    // Out-of-range fetches store a zero word with the error flag set.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[tail_q] <= in_range ? mem[rd_idx] : 32'h0;
            fifo_err_q[tail_q]   <= !in_range;
        end
    end

    // Program-load write port.
    // No fetch is accepted while prog_en is high, so no read can collide with this write.
    always_ff @(posedge clk) begin
        if (!reset && bus.prog_en) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Head-of-FIFO outputs. They are forced to zero when the FIFO is empty.
    always_comb begin
        bus.req_ready = req_ready_int;
        bus.rsp_valid = rsp_valid_int;
        bus.rsp_instr = 32'h0;
        bus.rsp_err   = 1'b0;
        if (rsp_valid_int) begin
            bus.rsp_instr = fifo_instr_q[head_q];
            bus.rsp_err   = fifo_err_q[head_q];
        end
    end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter AW, default 10: word-address width of the instruction store; DEPTH = 2**AW words of 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled at posedge clk.
REQ-004 req_valid  input  1  core presents a fetch request.
REQ-005 req_ready  output  1  responder accepts the request this cycle.
REQ-006 req_addr  input  32  instruction word index (the core's instr_pointer value).
REQ-007 rsp_valid  output  1  response word available at the FIFO head.
REQ-008 rsp_ready  input  1  core consumes the head response this cycle.
REQ-009 rsp_instr  output  32  fetched instruction.
REQ-010 rsp_err  output  1  head response was an out-of-range fetch.
REQ-011 flush  input  1  core redirect; discard all queued responses.
REQ-012 prog_en  input  1  program-load write strobe.
REQ-013 prog_addr  input  AW  program-load word address.
REQ-014 prog_data  input  32  program-load word.

Function
REQ-015 Storage SHALL be a DEPTH x 32 array with synchronous write and synchronous (registered) read; contents SHALL NOT be cleared by reset.
REQ-016 Response buffer SHALL be a 2-entry in-order FIFO of {instr[31:0], err}, with head pointer, tail pointer (1 bit each) and count (0..2).
REQ-017 Accept = req_valid && req_ready; on an accept edge the FIFO tail entry SHALL be loaded with mem[req_addr[AW-1:0]] and err=0 if req_addr < DEPTH, else instr=32'h0 and err=1.
REQ-018 Latency: a request accepted at edge N SHALL be visible at the head no earlier than cycle N+1; with an empty FIFO, rsp_valid SHALL be 1 in cycle N+1.
REQ-019 req_ready = !reset && !flush && !prog_en && (count < 2 || (rsp_valid && rsp_ready)); combinational from state and these inputs only, never from req_valid.
REQ-020 Sustained throughput SHALL be one response per cycle while req_valid and rsp_ready are both held high.
REQ-021 rsp_valid = (count != 0); rsp_instr/rsp_err SHALL be the head entry; when count == 0, rsp_instr = 0 and rsp_err = 0.
REQ-022 Pop = rsp_valid && rsp_ready; simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Once rsp_valid is asserted, the head entry SHALL stay stable until popped or flushed.
REQ-024 Full (count == 2) without pop: req_ready = 0 and no entry SHALL be overwritten.
REQ-025 flush at edge: count <- 0 and head/tail <- 0; flush SHALL override any simultaneous pop; no push occurs in a flush cycle.
REQ-026 prog_en at edge: mem[prog_addr] <- prog_data; no request is accepted while prog_en = 1; queued responses are unaffected and may still be popped.
REQ-027 Responses SHALL be returned strictly in acceptance order.
REQ-028 Pointer wrap: 1-bit pointers SHALL wrap 1 -> 0 with no lost or duplicated entries.

Reset
REQ-029 While reset = 1 at an edge: count <- 0, head <- 0, tail <- 0; all queued responses are discarded.
REQ-030 In the cycle after reset, outputs SHALL be: rsp_valid = 0, rsp_instr = 0, rsp_err = 0.
REQ-031 In the cycle after reset, req_ready = 1 unless flush or prog_en is asserted.
REQ-032 Reset asserted mid-stream SHALL drop in-flight and queued responses; reset SHALL take priority over flush, prog_en, push and pop.

Verification
REQ-033 Program mem[1] = 32'hA5A5_0001 and mem[2] = 32'h0000_BEEF; req addr 1 at edge N -> rsp_valid = 1 with rsp_instr = 32'hA5A5_0001 and rsp_err = 0 in cycle N+1.
REQ-034 Streaming: addrs 1, 2, 3, ... with req_valid = rsp_ready = 1 for 8 cycles -> one in-order response per cycle; req_ready never drops.
REQ-035 Backpressure: rsp_ready = 0, three requests -> first two accepted, req_ready = 0 with count = 2; raise rsp_ready -> third request accepted in the same cycle as the pop; order preserved.
REQ-036 Out of range: req_addr = 32'h0000_0400 (AW = 10) -> rsp_err = 1 and rsp_instr = 0.
REQ-037 Flush with count = 2 and req_valid = 1 -> next cycle rsp_valid = 0 and the flush-cycle request is not accepted; the following request returns correct data.
REQ-038 Reset asserted with count = 2 -> next cycle rsp_valid = 0 and req_ready = 1; memory contents retained, so re-fetching addr 1 returns 32'hA5A5_0001.
